// File: rtl/register_map_arbiter.sv
// Two-requester arbiter for the register_map write and read ports (A = host bus, B = engine).
// Round-robin by default; define REGMAP_ARB_FIXED_PRIO_EN for fixed A-over-B priority.
module register_map_arbiter #(
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [MEM_WIDTH-1:0]  wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [MEM_WIDTH-1:0]  rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [MEM_WIDTH-1:0]  wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [MEM_WIDTH-1:0]  rdata_b,
  output logic                  wr_strb,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [MEM_WIDTH-1:0]  wr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [MEM_WIDTH-1:0]  rd_data
);

  // Handshake: a requester holds req/we/addr/wdata stable; the access is taken in the
  // cycle gnt is high (gnt only ever rises while its req is high). Reads return with a
  // one-cycle rvalid pulse two cycles after gnt; rdata holds until the next return.
  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t                state;
  state_t                state_next;
  logic                  pick_b;
  logic                  grant;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [MEM_WIDTH-1:0]  win_wdata;
  logic                  owner;
`ifndef REGMAP_ARB_FIXED_PRIO_EN
  logic                  ptr;
`endif

  always_comb begin
    pick_b = req_b;
    if (req_a && req_b) begin
`ifdef REGMAP_ARB_FIXED_PRIO_EN
      pick_b = 1'b0;
`else
      pick_b = ptr;
`endif
    end
    win_we    = pick_b ? we_b    : we_a;
    win_addr  = pick_b ? addr_b  : addr_a;
    win_wdata = pick_b ? wdata_b : wdata_a;
    grant     = !reset && (state == IDLE) && (req_a || req_b);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant && !win_we) state_next = RD_WAIT;
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    wr_strb = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    if (grant) begin
      gnt_a = !pick_b;
      gnt_b = pick_b;
      if (win_we) begin
        wr_strb = 1'b1;
        wr_addr = win_addr;
        wr_data = win_wdata;
      end else begin
        rd_addr = win_addr;
      end
    end
  end

  // Read return: rd_data is valid during RD_WAIT and lands only in the owner's rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= (state == RD_WAIT) && !owner;
      rvalid_b <= (state == RD_WAIT) && owner;
      if (state == RD_WAIT) begin
        if (owner) rdata_b <= rd_data;
        else       rdata_a <= rd_data;
      end
      if (grant && !win_we) owner <= pick_b;
    end
  end

`ifndef REGMAP_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset)      ptr <= 1'b0;
    else if (grant) ptr <= !pick_b;
  end
`endif

endmodule

// File: tb/tb_register_map_arbiter.sv
// Self-checking bench for register_map_arbiter with a behavioural register_map stub.
// Honours REGMAP_ARB_FIXED_PRIO_EN when predicting tie-break winners.
module tb_register_map_arbiter;
  localparam int MW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [AW-1:0] addr_a = 0, addr_b = 0;
  logic [MW-1:0] wdata_a = 0, wdata_b = 0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, wr_strb;
  logic [MW-1:0] rdata_a, rdata_b, wr_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [MW-1:0] rd_data = '0;

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] regs    [16] = '{default: '0};
  logic [MW-1:0] ref_mem [16] = '{default: '0};
  logic [MW-1:0] exp_q_a [$];
  logic [MW-1:0] exp_q_b [$];

  always #5 clk = ~clk;

  register_map_arbiter #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // register_map stand-in: write on strobe, read data one cycle after rd_addr
  always @(posedge clk) begin
    if (wr_strb) regs[wr_addr] <= wr_data;
    rd_data <= regs[rd_addr];
  end

  task automatic idle();
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
  endtask

  task automatic drive_a(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] d);
    req_a = 1; we_a = we; addr_a = a; wdata_a = d;
  endtask

  task automatic drive_b(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] d);
    req_b = 1; we_b = we; addr_b = a; wdata_b = d;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; idle();
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1;
    drive_a(1, 4'd7, 32'h1111_2222); drive_b(0, 4'd9, 32'h0);
    #1;
    checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL rst_gnt_a: got %b want 0", gnt_a); end
    checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL rst_gnt_b: got %b want 0", gnt_b); end
    checks++; if (wr_strb !== 1'b0) begin errors++; $display("FAIL rst_wr_strb: got %b want 0", wr_strb); end
    checks++; if (wr_addr !== 4'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_bus: got %h/%h want 0/0", wr_addr, wr_data); end
    checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL rst_rd_addr: got %h want 0", rd_addr); end
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", rvalid_a, rvalid_b); end
    checks++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", rdata_a, rdata_b); end
    reset = 0; idle();
  endtask

  task automatic test_single_write();
    do_reset();
    drive_a(1, 4'd3, 32'hDEAD_BEEF); #1;
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL sw_gnt: got %b%b want 10", gnt_a, gnt_b); end
    checks++; if (wr_strb !== 1'b1) begin errors++; $display("FAIL sw_strb: got %b want 1", wr_strb); end
    checks++; if (wr_addr !== 4'd3 || wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_bus: got %h/%h want 3/deadbeef", wr_addr, wr_data); end
    ref_mem[3] = 32'hDEAD_BEEF;
    @(negedge clk); idle(); drive_b(0, 4'd3, 32'h0); #1;
    checks++; if (gnt_b !== 1'b1 || rd_addr !== 4'd3 || wr_strb !== 1'b0) begin errors++; $display("FAIL sw_rd_gnt: got gnt_b=%b rd_addr=%h strb=%b want 1/3/0", gnt_b, rd_addr, wr_strb); end
    @(negedge clk); idle(); #1;
    checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL sw_rd_wait: got gnt=%b%b rvalid_b=%b want 00/0", gnt_a, gnt_b, rvalid_b); end
    @(negedge clk);
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_rd_ret: got %b/%h want 1/deadbeef", rvalid_b, rdata_b); end
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL sw_rvalid_a: got %b want 0", rvalid_a); end
    @(negedge clk);
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL sw_rvalid_pulse: got %b want 0", rvalid_b); end
  endtask

  task automatic test_contention();
    logic want_a;
    logic [MW-1:0] da, db;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      da = $urandom; db = $urandom;
      drive_a(1, 4'(i), da); drive_b(1, 4'(i + 8), db); #1;
`ifdef REGMAP_ARB_FIXED_PRIO_EN
      want_a = 1'b1;
`else
      want_a = (i % 2 == 0);
`endif
      checks++; if (gnt_a !== want_a || gnt_b !== !want_a) begin errors++; $display("FAIL cont_gnt[%0d]: got %b%b want %b%b", i, gnt_a, gnt_b, want_a, !want_a); end
      checks++; if (wr_addr !== (want_a ? 4'(i) : 4'(i + 8))) begin errors++; $display("FAIL cont_addr[%0d]: got %h", i, wr_addr); end
      if (want_a) ref_mem[i] = da; else ref_mem[i + 8] = db;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_read_after_write();
    do_reset();
    drive_b(1, 4'd5, 32'h1234_5678); #1;
    checks++; if (gnt_b !== 1'b1 || wr_strb !== 1'b1) begin errors++; $display("FAIL raw_wr: got gnt_b=%b strb=%b want 1/1", gnt_b, wr_strb); end
    ref_mem[5] = 32'h1234_5678;
    @(negedge clk); idle(); drive_a(0, 4'd5, 32'h0); #1;
    checks++; if (gnt_a !== 1'b1 || rd_addr !== 4'd5) begin errors++; $display("FAIL raw_rd_gnt: got %b/%h want 1/5", gnt_a, rd_addr); end
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h1234_5678) begin errors++; $display("FAIL raw_ret: got %b/%h want 1/12345678", rvalid_a, rdata_a); end
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL raw_rvalid_b: got %b want 0", rvalid_b); end
  endtask

  task automatic test_read_bubble();
    do_reset();
    drive_a(0, 4'd1, 32'h0); drive_b(1, 4'd9, 32'hB0B0_0009); #1;
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL bub_first: got %b%b want 10", gnt_a, gnt_b); end
    @(negedge clk); req_a = 0; #1;
    checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL bub_wait: got gnt_b=%b want 0", gnt_b); end
    @(negedge clk); #1;
    checks++; if (gnt_b !== 1'b1 || wr_strb !== 1'b1 || wr_addr !== 4'd9) begin errors++; $display("FAIL bub_grant: got %b/%b/%h want 1/1/9", gnt_b, wr_strb, wr_addr); end
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== ref_mem[1]) begin errors++; $display("FAIL bub_ret: got %b/%h want 1/%h", rvalid_a, rdata_a, ref_mem[1]); end
    ref_mem[9] = 32'hB0B0_0009;
    @(negedge clk); idle();
  endtask

  task automatic test_reset_in_rd_wait();
    do_reset();
    drive_a(1, 4'd2, 32'hA5A5_0002); #1;
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL rrw_wr: got %b want 1", gnt_a); end
    ref_mem[2] = 32'hA5A5_0002;
    @(negedge clk); drive_a(0, 4'd2, 32'h0);
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hA5A5_0002) begin errors++; $display("FAIL rrw_pre: got %b/%h want 1/a5a50002", rvalid_a, rdata_a); end
    drive_a(0, 4'd2, 32'h0); #1;
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL rrw_rd_gnt: got %b want 1", gnt_a); end
    @(negedge clk); idle(); reset = 1;
    @(negedge clk); reset = 0;
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 32'd0) begin errors++; $display("FAIL rrw_discard: got %b/%h want 0/0", rvalid_a, rdata_a); end
    drive_a(1, 4'd4, 32'h4444_0004); #1;
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL rrw_regrant: got %b want 1", gnt_a); end
    ref_mem[4] = 32'h4444_0004;
    @(negedge clk); idle();
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL rrw_no_late: got %b want 0", rvalid_a); end
  endtask

  task automatic test_address_wrap();
    logic [MW-1:0] v;
    v = $urandom | 32'h1;
    do_reset();
    drive_a(1, 4'd15, v); #1;
    checks++; if (gnt_a !== 1'b1 || wr_addr !== 4'd15) begin errors++; $display("FAIL wrap_wr: got %b/%h want 1/f", gnt_a, wr_addr); end
    ref_mem[15] = v;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive_a(0, (k == 0) ? 4'd15 : 4'd0, 32'h0); #1;
      checks++; if (rd_addr !== ((k == 0) ? 4'd15 : 4'd0)) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %h", k, rd_addr); end
      @(negedge clk); idle();
      @(negedge clk);
      checks++; if (rvalid_a !== 1'b1 || rdata_a !== ((k == 0) ? v : ref_mem[0])) begin errors++; $display("FAIL wrap_ret[%0d]: got %b/%h want 1/%h", k, rvalid_a, rdata_a, (k == 0) ? v : ref_mem[0]); end
    end
  endtask

  // Random traffic versus a transaction-level model: one outstanding read, ptr, memory image.
  task automatic test_random();
    logic pa, wa, pb, wb, busy, bown, ptr, tie_b, win_b, any, w_we, e_rva, e_rvb;
    logic [AW-1:0] aa, ab, w_addr;
    logic [MW-1:0] da, db, w_data, e_rda, e_rdb;
    pa = 0; pb = 0; wa = 0; wb = 0; aa = 0; ab = 0; da = 0; db = 0;
    busy = 0; bown = 0; ptr = 0; e_rva = 0; e_rvb = 0; e_rda = 0; e_rdb = 0;
    exp_q_a.delete(); exp_q_b.delete();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      checks++; if (rvalid_a !== e_rva || rdata_a !== e_rda) begin errors++; $display("FAIL rnd_ret_a[%0d]: got %b/%h want %b/%h", c, rvalid_a, rdata_a, e_rva, e_rda); end
      checks++; if (rvalid_b !== e_rvb || rdata_b !== e_rdb) begin errors++; $display("FAIL rnd_ret_b[%0d]: got %b/%h want %b/%h", c, rvalid_b, rdata_b, e_rvb, e_rdb); end
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1; wa = $urandom_range(0, 1); aa = $urandom; da = $urandom;
      end else if (pa && $urandom_range(0, 15) == 0) pa = 0;
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1; wb = $urandom_range(0, 1); ab = $urandom; db = $urandom;
      end else if (pb && $urandom_range(0, 15) == 0) pb = 0;
      req_a = pa; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = pb; we_b = wb; addr_b = ab; wdata_b = db;
      #1;
`ifdef REGMAP_ARB_FIXED_PRIO_EN
      tie_b = 1'b0;
`else
      tie_b = ptr;
`endif
      any    = !busy && (pa || pb);
      win_b  = (pa && pb) ? tie_b : pb;
      w_we   = win_b ? wb : wa;
      w_addr = win_b ? ab : aa;
      w_data = win_b ? db : da;
      checks++; if (gnt_a !== (any && !win_b) || gnt_b !== (any && win_b)) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b", c, gnt_a, gnt_b, any && !win_b, any && win_b); end
      checks++; if (wr_strb !== (any && w_we) || wr_addr !== ((any && w_we) ? w_addr : 4'd0) || wr_data !== ((any && w_we) ? w_data : 32'd0)) begin errors++; $display("FAIL rnd_wr[%0d]: got %b/%h/%h", c, wr_strb, wr_addr, wr_data); end
      checks++; if (rd_addr !== ((any && !w_we) ? w_addr : 4'd0)) begin errors++; $display("FAIL rnd_rd_addr[%0d]: got %h", c, rd_addr); end
      e_rva = busy && !bown;
      e_rvb = busy && bown;
      if (e_rva && exp_q_a.size() > 0) e_rda = exp_q_a.pop_front();
      if (e_rvb && exp_q_b.size() > 0) e_rdb = exp_q_b.pop_front();
      busy = 0;
      if (any) begin
        if (w_we) ref_mem[w_addr] = w_data;
        else begin
          busy = 1; bown = win_b;
          if (win_b) exp_q_b.push_back(ref_mem[w_addr]);
          else       exp_q_a.push_back(ref_mem[w_addr]);
        end
        ptr = !win_b;
        if (win_b) pb = 0; else pa = 0;
      end
    end
    @(negedge clk); idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_write();
    test_contention();
    test_read_after_write();
    test_read_bubble();
    test_reset_in_rd_wait();
    test_address_wrap();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
